// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way cache controller.
// FSM encoding, line-status bit positions and tag-width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  localparam int META_W    = 2;
  localparam int VALID_BIT = 0;
  localparam int DIRTY_BIT = 1;

  function automatic int tag_w(
    input int addr_w,
    input int idx_w,
    input int off_w
  );
    return addr_w - idx_w - off_w;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid/dirty status plus tag and data.
// Status bits reset asynchronously; tag and data arrays are not cleared.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 25,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  input  logic              meta_we,
  input  logic [META_W-1:0] meta_wd,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              data_we,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int SETS = 2**IDX_W;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= meta_wd[VALID_BIT];
      dirty_q[idx] <= meta_wd[DIRTY_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)
      tag_q[idx] <= wr_tag;
    if (data_we)
      data_q[idx] <= wr_data;
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/cache_controller_2way.sv
// 2-way set-associative write-back/write-allocate cache controller.
// Define CACHE_STATS_EN to enable the hit/miss counters.
module cache_controller_2way
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] cpu2cache_addr,
  input  logic [DATA_W-1:0] cpu2cache_data_in,
  input  logic              cpu2cache_rw,
  input  logic              cpu2cache_valid,
  output logic [DATA_W-1:0] cache2cpu_data_out,
  output logic              cache2cpu_ready,
  output logic [ADDR_W-1:0] cache2mem_addr,
  output logic [DATA_W-1:0] cache2mem_data_out,
  output logic              cache2mem_MemWrite,
  output logic              cache2mem_MemRead,
  input  logic [DATA_W-1:0] mem2cache_data_in,
  input  logic              mem2cache_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int TAG_W  = tag_w(ADDR_W, IDX_W, OFFSET_W);
  localparam int SETS   = 2**IDX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_t state_q, state_d;

  logic [LINE_W-1:0] line_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic              victim_q;
  logic [SETS-1:0]   lru_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;

  logic [TAG_W-1:0]  way_tag  [2];
  logic [DATA_W-1:0] way_data [2];
  logic [1:0]        way_valid;
  logic [1:0]        way_dirty;
  logic [1:0]        hit;
  logic              hit_any;
  logic              hit_way;
  logic              miss_way;

  logic [1:0]        meta_we;
  logic [1:0]        tag_we;
  logic [1:0]        data_we;
  logic [META_W-1:0] meta_wd;
  logic [DATA_W-1:0] wr_data;

  // Byte-offset bits never select anything in a one-word line.
  logic unused_off;
  assign unused_off = ^cpu2cache_addr[OFFSET_W-1:0];

  assign idx     = line_q[IDX_W-1:0];
  assign req_tag = line_q[LINE_W-1 -: TAG_W];

  cache_way_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_way0 (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .idx      (idx),
    .rd_tag   (way_tag[0]),
    .rd_data  (way_data[0]),
    .rd_valid (way_valid[0]),
    .rd_dirty (way_dirty[0]),
    .meta_we  (meta_we[0]),
    .meta_wd  (meta_wd),
    .tag_we   (tag_we[0]),
    .wr_tag   (req_tag),
    .data_we  (data_we[0]),
    .wr_data  (wr_data)
  );

  cache_way_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_way1 (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .idx      (idx),
    .rd_tag   (way_tag[1]),
    .rd_data  (way_data[1]),
    .rd_valid (way_valid[1]),
    .rd_dirty (way_dirty[1]),
    .meta_we  (meta_we[1]),
    .meta_wd  (meta_wd),
    .tag_we   (tag_we[1]),
    .wr_tag   (req_tag),
    .data_we  (data_we[1]),
    .wr_data  (wr_data)
  );

  assign hit[0]   = way_valid[0] && (way_tag[0] == req_tag);
  assign hit[1]   = way_valid[1] && (way_tag[1] == req_tag);
  assign hit_any  = |hit;
  assign hit_way  = hit[1];
  // Fill an empty way before evicting; otherwise the LRU way goes.
  assign miss_way = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[idx];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (cpu2cache_valid)
          state_d = S_COMPARE;
      S_COMPARE:
        if (hit_any)
          state_d = S_IDLE;
        else if (way_dirty[miss_way])
          state_d = S_WRITEBACK;
        else
          state_d = S_ALLOCATE;
      S_WRITEBACK:
        if (mem2cache_ready)
          state_d = S_ALLOCATE;
      S_ALLOCATE:
        if (mem2cache_ready)
          state_d = S_COMPARE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cache2mem_MemRead  = 1'b0;
    cache2mem_MemWrite = 1'b0;
    cache2mem_addr     = '0;
    cache2mem_data_out = '0;
    meta_we            = '0;
    tag_we             = '0;
    data_we            = '0;
    meta_wd            = '0;
    wr_data            = wdata_q;
    unique case (state_q)
      S_COMPARE:
        if (hit_any && rw_q) begin
          meta_we[hit_way]   = 1'b1;
          data_we[hit_way]   = 1'b1;
          meta_wd[VALID_BIT] = 1'b1;
          meta_wd[DIRTY_BIT] = 1'b1;
        end
      S_WRITEBACK: begin
        cache2mem_MemWrite = 1'b1;
        cache2mem_addr     = {way_tag[victim_q], idx,
                              {OFFSET_W{1'b0}}};
        cache2mem_data_out = way_data[victim_q];
        if (mem2cache_ready) begin
          meta_we[victim_q]  = 1'b1;
          meta_wd[VALID_BIT] = 1'b1;
        end
      end
      S_ALLOCATE: begin
        cache2mem_MemRead = 1'b1;
        cache2mem_addr    = {req_tag, idx, {OFFSET_W{1'b0}}};
        if (mem2cache_ready) begin
          meta_we[victim_q]  = 1'b1;
          tag_we[victim_q]   = 1'b1;
          data_we[victim_q]  = 1'b1;
          meta_wd[VALID_BIT] = 1'b1;
          wr_data            = mem2cache_data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      line_q             <= '0;
      wdata_q            <= '0;
      rw_q               <= 1'b0;
      victim_q           <= 1'b0;
      lru_q              <= '0;
      cache2cpu_ready    <= 1'b0;
      cache2cpu_data_out <= '0;
    end else begin
      cache2cpu_ready <= 1'b0;
      unique case (state_q)
        S_IDLE:
          if (cpu2cache_valid) begin
            line_q  <= cpu2cache_addr[ADDR_W-1:OFFSET_W];
            wdata_q <= cpu2cache_data_in;
            rw_q    <= cpu2cache_rw;
          end
        S_COMPARE:
          if (hit_any) begin
            cache2cpu_ready <= 1'b1;
            lru_q[idx]      <= ~hit_way;
            if (!rw_q)
              cache2cpu_data_out <= way_data[hit_way];
          end else begin
            victim_q <= miss_way;
          end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Post-fill re-compare completes a request already counted as a miss.
  logic refill_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      refill_q <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state_q == S_ALLOCATE && mem2cache_ready)
        refill_q <= 1'b1;
      else if (state_q == S_COMPARE)
        refill_q <= 1'b0;
      if (state_q == S_COMPARE) begin
        if (!hit_any)
          miss_cnt <= miss_cnt + 32'd1;
        else if (!refill_q)
          hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: doc/cache_controller_2way.md
CACHE_CONTROLLER_2WAY -- requirements
Module: cache_controller_2way

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32, meaning CPU/memory byte-address width.
- REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; one word per line.
- REQ-003 SHALL have parameter OFFSET_W, default 2, meaning byte-offset bits, ignored for indexing.
- REQ-004 SHALL have parameter IDX_W, default 5, meaning set-index bits (2**IDX_W sets); TAG_W = ADDR_W-IDX_W-OFFSET_W.
- REQ-005 SHALL have ports: iCLK in 1 clock; iRST_n in 1 reset; the clock is iCLK and the reset is iRST_n, asynchronous, active-low.
- REQ-006 SHALL have CPU-side ports: cpu2cache_addr in ADDR_W; cpu2cache_data_in in DATA_W; cpu2cache_rw in 1 (0 read, 1 write); cpu2cache_valid in 1 request.
- REQ-007 SHALL have CPU-result ports: cache2cpu_data_out out DATA_W read data; cache2cpu_ready out 1 completion pulse.
- REQ-008 SHALL have memory-side ports: cache2mem_addr out ADDR_W; cache2mem_data_out out DATA_W; cache2mem_MemWrite out 1; cache2mem_MemRead out 1; mem2cache_data_in in DATA_W; mem2cache_ready in 1.
- REQ-009 SHALL have stats ports: hit_cnt out 32; miss_cnt out 32.

Function
- REQ-010 SHALL be 2-way set-associative, write-back, write-allocate; per way per set: valid, dirty, tag, data; per set: one LRU bit naming the least-recently-used way.
- REQ-011 SHALL implement FSM IDLE, COMPARE, WRITEBACK, ALLOCATE.
- REQ-012 IDLE: at an edge with cpu2cache_valid=1, latch addr/data/rw, go to COMPARE; else stay.
- REQ-013 COMPARE hit (valid & tag match in either way): read -> data_out=line data; write -> line data=latched data, dirty=1; LRU=other way; ready=1 for exactly one cycle; go to IDLE.
- REQ-014 Hit latency SHALL be 2 edges from the sampling edge; ready asserted in the cycle after the second edge.
- REQ-015 COMPARE miss: victim = way0 if invalid, else way1 if invalid, else LRU way; victim dirty -> WRITEBACK, else ALLOCATE.
- REQ-016 WRITEBACK: MemWrite=1, addr={victim tag, index, OFFSET_W'0}, data_out=victim data, held stable until mem2cache_ready=1 sampled; then clear dirty, go to ALLOCATE.
- REQ-017 ALLOCATE: MemRead=1, addr={request tag, index, OFFSET_W'0} held until mem2cache_ready=1; then victim valid=1, tag=request tag, data=mem2cache_data_in, dirty=0; go to COMPARE (which then hits).
- REQ-018 MemRead and MemWrite SHALL never be high together; both low in IDLE and COMPARE.
- REQ-019 Deassertion of cpu2cache_valid or input changes after the sampling edge SHALL be ignored; the latched transaction completes.
- REQ-020 cache2cpu_data_out SHALL hold its last value between reads.
- REQ-021 A request equal to the address just filled SHALL hit in COMPARE with no further memory traffic.

Reset
- REQ-022 iRST_n low SHALL asynchronously force IDLE, clear all valid, dirty and LRU bits, ready=0, MemRead=0, MemWrite=0, data_out=0, cache2mem_addr=0, cache2mem_data_out=0, hit_cnt=0, miss_cnt=0.
- REQ-023 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transfer; no line is updated.
- REQ-024 Tag and data arrays need not be cleared.

Configuration
- REQ-025 Macro CACHE_STATS_EN defined: hit_cnt increments on each COMPARE hit that completes a request (not the post-fill re-compare); miss_cnt increments on each COMPARE miss; both wrap at 2**32.
- REQ-026 CACHE_STATS_EN undefined: hit_cnt and miss_cnt SHALL be constant 0, ports still present, no counter logic.

Structure
- REQ-027 Shared package cache_pkg SHALL hold FSM state encoding and TAG_W/valid/dirty bit-position constants.
- REQ-028 Sub-module cache_way_array (one per way: tag/valid/dirty/data storage with index read and write-enable ports) SHALL be instantiated twice.

Verification
- REQ-029 Read addr 0x4 on cold cache, mem returns 3 -> one MemRead at 0x4, ready pulse, data_out=3, miss_cnt=1.
- REQ-030 Read 0x4 again -> ready 2 edges after valid, no Mem strobe, data_out=3, hit_cnt=1.
- REQ-031 Write 5 to 0x4 (hit), then read 0x84 and 0x104 (same set 1) -> 0x84 fills way1; 0x104 evicts LRU way0: MemWrite addr 0x4 data 5, then MemRead 0x104.
- REQ-032 Read 0x84 after REQ-031 sequence -> hit, no Mem traffic (LRU correctness).
- REQ-033 Assert iRST_n low while MemRead high -> MemRead drops immediately; next read 0x4 misses.
- REQ-034 Drop cpu2cache_valid one cycle into a miss -> transfer completes, exactly one ready pulse.
